// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode stage of a 5-stage RV32I pipeline together with its ID/EX register.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   if_valid/if_instr/if_pc   instruction held in IF/ID
//   flush                 redirect from EX; the instruction entering ID/EX dies
//   read_reg1/read_reg2   RegisterFile read addresses (combinational)
//   read_data1/read_data2 RegisterFile read data
//   wb_reg_write/wb_rd/wb_data  writeback port, bypassed into the operands
//   stall                 load-use hazard: hold PC and IF/ID this cycle
//   ex_*                  registered decode results for the EX stage
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [4:0]      read_reg1,
    output logic [4:0]      read_reg2,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_branch,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_lui,
    output logic            ex_auipc
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;

    assign opcode    = if_instr[6:0];
    assign rd        = if_instr[11:7];
    assign rs1       = if_instr[19:15];
    assign rs2       = if_instr[24:20];
    assign read_reg1 = rs1;
    assign read_reg2 = rs2;

    // Immediate formats, all sign-extended from instr[31] except U.
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

    logic            legal, use_rs1, use_rs2;
    logic            c_reg_write, c_mem_read, c_mem_write, c_alu_src;
    logic            c_branch, c_jal, c_jalr, c_lui, c_auipc;
    logic [XLEN-1:0] imm;

    always_comb begin
        legal       = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        c_reg_write = 1'b0;
        c_mem_read  = 1'b0;
        c_mem_write = 1'b0;
        c_alu_src   = 1'b0;
        c_branch    = 1'b0;
        c_jal       = 1'b0;
        c_jalr      = 1'b0;
        c_lui       = 1'b0;
        c_auipc     = 1'b0;
        imm         = '0;
        case (opcode)
            OP_R: begin
                legal = 1'b1; c_reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IALU: begin
                legal = 1'b1; c_reg_write = 1'b1; c_alu_src = 1'b1; use_rs1 = 1'b1;
                imm = imm_i;
            end
            OP_LOAD: begin
                legal = 1'b1; c_reg_write = 1'b1; c_mem_read = 1'b1; c_alu_src = 1'b1;
                use_rs1 = 1'b1; imm = imm_i;
            end
            OP_STORE: begin
                legal = 1'b1; c_mem_write = 1'b1; c_alu_src = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
            end
            OP_BRANCH: begin
                legal = 1'b1; c_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm = imm_b;
            end
            OP_JAL: begin
                legal = 1'b1; c_jal = 1'b1; c_reg_write = 1'b1; imm = imm_j;
            end
            OP_JALR: begin
                legal = 1'b1; c_jalr = 1'b1; c_reg_write = 1'b1; c_alu_src = 1'b1;
                use_rs1 = 1'b1; imm = imm_i;
            end
            OP_LUI: begin
                legal = 1'b1; c_lui = 1'b1; c_reg_write = 1'b1; imm = imm_u;
            end
            OP_AUIPC: begin
                legal = 1'b1; c_auipc = 1'b1; c_reg_write = 1'b1; imm = imm_u;
            end
            default: ;
        endcase
    end

    // Operand select: x0 is hard-wired zero, a same-cycle writeback wins
    // over the (not yet updated) RegisterFile read.
    logic [XLEN-1:0] op1, op2;
    always_comb begin
        op1 = read_data1;
        op2 = read_data2;
        if (WB_BYPASS != 0 && wb_reg_write && wb_rd != 5'd0) begin
            if (wb_rd == rs1) op1 = wb_data;
            if (wb_rd == rs2) op2 = wb_data;
        end
        if (rs1 == 5'd0) op1 = '0;
        if (rs2 == 5'd0) op2 = '0;
    end

    // Load-use: the load in ID/EX has no data until MEM, so one bubble is
    // inserted. Index 0 is excluded through ex_rd != 0.
    logic hazard;
    assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));
    assign stall  = if_valid & hazard & ~flush;

    logic capture;
    assign capture = if_valid & legal & ~flush & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jal       <= 1'b0;
            ex_jalr      <= 1'b0;
            ex_lui       <= 1'b0;
            ex_auipc     <= 1'b0;
        end else begin
            // Data fields load every cycle; a bubble is defined by ex_valid
            // and the control bits alone.
            ex_valid     <= capture;
            ex_pc        <= if_pc;
            ex_rs1_data  <= op1;
            ex_rs2_data  <= op2;
            ex_imm       <= imm;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_rd        <= rd;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_reg_write <= capture & c_reg_write & (rd != 5'd0);
            ex_mem_read  <= capture & c_mem_read;
            ex_mem_write <= capture & c_mem_write;
            ex_alu_src   <= capture & c_alu_src;
            ex_branch    <= capture & c_branch;
            ex_jal       <= capture & c_jal;
            ex_jalr      <= capture & c_jalr;
            ex_lui       <= capture & c_lui;
            ex_auipc     <= capture & c_auipc;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. Two instances share all inputs: one with
// the writeback bypass enabled, one without. Stimulus computes expected ID/EX
// contents and stall from an instruction-level reference model and queues
// them; a monitor process pops and compares.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    // control vector bit positions
    localparam int C_RW = 8, C_MR = 7, C_MW = 6, C_AS = 5, C_BR = 4;
    localparam int C_JAL = 3, C_JALR = 2, C_LUI = 1, C_AUIPC = 0;

    typedef struct {
        logic        valid;
        logic [8:0]  ctrl;
        logic        chk;
        logic [31:0] pc, d1, d2, d1nb, d2nb, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0, if_pc = '0;
    logic        flush = 1'b0;
    logic [31:0] read_data1 = '0, read_data2 = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    logic [4:0]  read_reg1, read_reg2;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic        ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc;

    logic [4:0]  nb_read_reg1, nb_read_reg2;
    logic        nb_stall, nb_ex_valid;
    logic [31:0] nb_ex_pc, nb_ex_rs1_data, nb_ex_rs2_data, nb_ex_imm;
    logic [4:0]  nb_ex_rs1, nb_ex_rs2, nb_ex_rd;
    logic [2:0]  nb_ex_funct3;
    logic        nb_ex_funct7b5, nb_ex_reg_write, nb_ex_mem_read, nb_ex_mem_write;
    logic        nb_ex_alu_src, nb_ex_branch, nb_ex_jal, nb_ex_jalr, nb_ex_lui, nb_ex_auipc;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_lui(ex_lui), .ex_auipc(ex_auipc)
    );

    id_ex_stage #(.XLEN(32), .WB_BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .read_reg1(nb_read_reg1), .read_reg2(nb_read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(nb_stall), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc),
        .ex_rs1_data(nb_ex_rs1_data), .ex_rs2_data(nb_ex_rs2_data), .ex_imm(nb_ex_imm),
        .ex_rs1(nb_ex_rs1), .ex_rs2(nb_ex_rs2), .ex_rd(nb_ex_rd), .ex_funct3(nb_ex_funct3),
        .ex_funct7b5(nb_ex_funct7b5), .ex_reg_write(nb_ex_reg_write),
        .ex_mem_read(nb_ex_mem_read), .ex_mem_write(nb_ex_mem_write),
        .ex_alu_src(nb_ex_alu_src), .ex_branch(nb_ex_branch), .ex_jal(nb_ex_jal),
        .ex_jalr(nb_ex_jalr), .ex_lui(nb_ex_lui), .ex_auipc(nb_ex_auipc)
    );

    int errors = 0;
    int checks = 0;
    exp_t ex_q[$];
    logic stall_q[$];

    // reference model state: what ID/EX is expected to hold right now
    logic       m_valid = 1'b0, m_mem_read = 1'b0, m_stall = 1'b0;
    logic [4:0] m_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Instruction-level semantics of RV32I decode.
    function automatic void decode(input logic [31:0] i, output logic legal,
                                   output logic [8:0] ctrl, output logic u1,
                                   output logic u2, output logic [31:0] imm);
        logic [31:0] ii, si, bi, ui, ji;
        ii = 32'($signed(i[31:20]));
        si = 32'($signed({i[31:25], i[11:7]}));
        bi = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        ui = {i[31:12], 12'h000};
        ji = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        legal = 1'b1; ctrl = '0; u1 = 1'b0; u2 = 1'b0; imm = 32'h0;
        case (i[6:0])
            7'b0110011: begin ctrl[C_RW] = 1; u1 = 1; u2 = 1; end
            7'b0010011: begin ctrl[C_RW] = 1; ctrl[C_AS] = 1; u1 = 1; imm = ii; end
            7'b0000011: begin ctrl[C_RW] = 1; ctrl[C_MR] = 1; ctrl[C_AS] = 1; u1 = 1; imm = ii; end
            7'b0100011: begin ctrl[C_MW] = 1; ctrl[C_AS] = 1; u1 = 1; u2 = 1; imm = si; end
            7'b1100011: begin ctrl[C_BR] = 1; u1 = 1; u2 = 1; imm = bi; end
            7'b1101111: begin ctrl[C_JAL] = 1; ctrl[C_RW] = 1; imm = ji; end
            7'b1100111: begin ctrl[C_JALR] = 1; ctrl[C_RW] = 1; ctrl[C_AS] = 1; u1 = 1; imm = ii; end
            7'b0110111: begin ctrl[C_LUI] = 1; ctrl[C_RW] = 1; imm = ui; end
            7'b0010111: begin ctrl[C_AUIPC] = 1; ctrl[C_RW] = 1; imm = ui; end
            default: legal = 1'b0;
        endcase
        if (i[11:7] == 5'd0) ctrl[C_RW] = 1'b0;
    endfunction

    // One cycle of stimulus: drive at negedge, predict, queue expectations.
    task automatic step(input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic fl,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
        logic legal, u1, u2, st;
        logic [8:0] ctrl;
        logic [31:0] imm;
        logic [4:0] s1, s2;
        exp_t e;
        @(negedge clk);
        rst = r; if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
        read_data1 = rd1; read_data2 = rd2;
        wb_reg_write = wbw; wb_rd = wbrd; wb_data = wbd;
        #1;
        if (r) chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("read_reg1", 32'(read_reg1), 32'(ins[19:15]));
        chk("read_reg2", 32'(read_reg2), 32'(ins[24:20]));
        decode(ins, legal, ctrl, u1, u2, imm);
        s1 = ins[19:15];
        s2 = ins[24:20];
        st = !r && v && m_valid && m_mem_read && m_rd != 0 &&
             ((u1 && s1 == m_rd) || (u2 && s2 == m_rd)) && !fl;
        stall_q.push_back(st);
        e.pc = '0; e.d1 = '0; e.d2 = '0; e.d1nb = '0; e.d2nb = '0; e.imm = '0;
        e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.f3 = '0; e.f7 = 1'b0;
        e.valid = 1'b0; e.ctrl = '0; e.chk = 1'b0;
        if (r) begin
            e.chk = 1'b1;
        end else if (v && legal && !fl && !st) begin
            e.valid = 1'b1; e.ctrl = ctrl; e.chk = 1'b1;
            e.pc = pc; e.imm = imm; e.rs1 = s1; e.rs2 = s2; e.rd = ins[11:7];
            e.f3 = ins[14:12]; e.f7 = ins[30];
            e.d1nb = (s1 == 0) ? 32'h0 : rd1;
            e.d2nb = (s2 == 0) ? 32'h0 : rd2;
            e.d1 = (s1 != 0 && wbw && wbrd == s1) ? wbd : e.d1nb;
            e.d2 = (s2 != 0 && wbw && wbrd == s2) ? wbd : e.d2nb;
        end
        ex_q.push_back(e);
        m_valid = e.valid; m_mem_read = e.ctrl[C_MR]; m_rd = e.rd; m_stall = st;
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic ins(input logic [31:0] i, input logic fl);
        step(1'b0, 1'b1, i, 32'h1000, fl, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: ex_* checked just after each posedge, stall mid-low-phase.
    initial begin : monitor
        exp_t e;
        logic s;
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                e = ex_q.pop_front();
                chk("ex_valid", 32'(ex_valid), 32'(e.valid));
                chk("nb_ex_valid", 32'(nb_ex_valid), 32'(e.valid));
                chk("ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                                    ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc}), 32'(e.ctrl));
                if (e.chk) begin
                    chk("ex_pc", ex_pc, e.pc);
                    chk("ex_rs1_data", ex_rs1_data, e.d1);
                    chk("ex_rs2_data", ex_rs2_data, e.d2);
                    chk("nb_ex_rs1_data", nb_ex_rs1_data, e.d1nb);
                    chk("nb_ex_rs2_data", nb_ex_rs2_data, e.d2nb);
                    chk("ex_imm", ex_imm, e.imm);
                    chk("ex_rs1", 32'(ex_rs1), 32'(e.rs1));
                    chk("ex_rs2", 32'(ex_rs2), 32'(e.rs2));
                    chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                    chk("ex_funct3", 32'(ex_funct3), 32'(e.f3));
                    chk("ex_funct7b5", 32'(ex_funct7b5), 32'(e.f7));
                end
                $display("txn %0d: ex_valid=%b rd=%0d imm=%h ctrl=%b", n, ex_valid, ex_rd,
                         ex_imm, e.ctrl);
                n++;
            end
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                chk("stall", 32'(stall), 32'(s));
                chk("nb_stall", 32'(nb_stall), 32'(s));
            end
        end
    end

    initial begin : stimulus
        logic [31:0] prev_i, prev_pc, ri, rpc;
        logic prev_v, rv;
        logic [6:0] ops [10];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

        // reset with a valid addi x5,x0,5 presented
        step(1'b1, 1'b1, 32'h00500293, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(1'b1, 1'b1, 32'h00500293, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b1, 32'h00500293, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("addi_imm", ex_imm, 32'h5);
        chk("addi_rd", 32'(ex_rd), 32'd5);

        // writeback bypass: add x10,x5,x0 with stale RegisterFile data
        step(1'b0, 1'b1, 32'h00028533, 32'h104, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'd999);
        settle();
        chk("bypass_on", ex_rs1_data, 32'd999);
        chk("bypass_off", nb_ex_rs1_data, 32'd0);

        // load-use: lw x6,0(x5); add x7,x6,x6 (held for a second cycle)
        ins(32'h0002A303, 1'b0);
        ins(32'h006303B3, 1'b0);
        ins(32'h006303B3, 1'b0);
        // load to x0 then use of x0: no stall
        ins(32'h0002A003, 1'b0);
        ins(32'h000003B3, 1'b0);

        // flush on normal capture, then flush during a load-use
        ins(32'h00500293, 1'b1);
        ins(32'h0002A303, 1'b0);
        ins(32'h006303B3, 1'b1);

        // immediate formats and an illegal opcode
        ins(32'hFE20AE23, 1'b0);
        settle();
        chk("imm_sw", ex_imm, 32'hFFFFFFFC);
        ins(32'hFE000CE3, 1'b0);
        settle();
        chk("imm_beq", ex_imm, 32'hFFFFFFF8);
        ins(32'hABCDE1B7, 1'b0);
        settle();
        chk("imm_lui", ex_imm, 32'hABCDE000);
        ins(32'h001000EF, 1'b0);
        settle();
        chk("imm_jal", ex_imm, 32'h00000800);
        ins(32'h0000007F, 1'b0);

        // reset arriving while a load-use would stall
        ins(32'h0002A303, 1'b0);
        step(1'b1, 1'b1, 32'h006303B3, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(1'b0);

        // randomized traffic; IF/ID holds its instruction while stalled
        prev_i = 32'h0; prev_pc = 32'h0; prev_v = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (m_stall) begin
                ri = prev_i; rpc = prev_pc; rv = prev_v;
            end else begin
                ri = {$urandom()} & 32'hFE007000;
                ri[6:0] = ops[$urandom_range(0, 9)];
                ri[11:7] = 5'($urandom_range(0, 7));
                ri[19:15] = 5'($urandom_range(0, 7));
                ri[24:20] = 5'($urandom_range(0, 7));
                rpc = $urandom() & 32'hFFFFFFFC;
                rv = ($urandom_range(0, 7) != 0);
            end
            step(($urandom_range(0, 60) == 0), rv, ri, rpc, ($urandom_range(0, 9) == 0),
                 $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom());
            prev_i = ri; prev_pc = rpc; prev_v = rv;
        end

        idle(1'b0);
        idle(1'b0);
        settle();
        @(negedge clk);
        #3;
        chk("ex_queue_drained", 32'(ex_q.size()), 32'd0);
        chk("stall_queue_drained", 32'(stall_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline, plus its ID/EX pipeline register.
- Takes the IF/ID instruction and drives the RegisterFile read addresses (read_reg1/read_reg2).
- Bypasses same-cycle writeback data, decodes control and immediates, and detects load-use hazards.
- Registers everything into ID/EX for the EX stage, with stall and flush control.

Parameters:
XLEN, 32, datapath width; only 32 supported.
WB_BYPASS, 1, 1 = forward the writeback port into the operands; 0 = use raw RegisterFile data.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
if_valid  in  1  IF/ID holds a valid instruction.
if_instr  in  32  IF/ID instruction.
if_pc  in  32  IF/ID PC.
flush  in  1  branch/jump redirect from EX; kill the instruction entering ID/EX.
read_reg1  out  5  to RegisterFile; equals if_instr[19:15], combinational.
read_reg2  out  5  to RegisterFile; equals if_instr[24:20], combinational.
read_data1  in  32  from RegisterFile.
read_data2  in  32  from RegisterFile.
wb_reg_write  in  1  writeback enable, same signal driven to RegisterFile reg_write.
wb_rd  in  5  writeback destination.
wb_data  in  32  writeback data.
stall  out  1  hold PC and IF/ID this cycle; combinational.
ex_valid  out  1  ID/EX holds a live instruction.
ex_pc  out  32  registered PC.
ex_rs1_data, ex_rs2_data  out  32 each  registered operands.
ex_imm  out  32  registered sign-extended immediate.
ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices, for the forwarding unit.
ex_funct3  out  3  registered funct3.
ex_funct7b5  out  1  registered instr[30].
ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc  out  1 each  registered control.

Behaviour:
- Reset (asynchronous, active-high): all ex_* outputs go to 0, including ex_valid. stall is 0 while rst=1.
- Latency: one cycle. An instruction present at posedge N appears on the ex_* outputs after posedge N.
- Decode by opcode:
  - R 0110011: reg_write.
  - I-ALU 0010011: reg_write, alu_src.
  - LOAD 0000011: reg_write, mem_read, alu_src.
  - STORE 0100011: mem_write, alu_src.
  - BRANCH 1100011: branch.
  - JAL 1101111: jal, reg_write.
  - JALR 1100111: jalr, reg_write, alu_src.
  - LUI 0110111: lui, reg_write.
  - AUIPC 0010111: auipc, reg_write.
  - Any other opcode: treated as a bubble (ex_valid=0, all control 0).
- reg_write is forced to 0 when rd=x0.
- Immediates: I, S, B, U and J formats per the RV32I spec. B and J have bit 0 = 0. U is instr[31:12]<<12. All others are sign-extended from instr[31]. R-type: ex_imm=0.
- Register use:
  - rs1 is used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by R, STORE, BRANCH.
  - Index 0 never counts as a use.
- WB bypass (WB_BYPASS=1): if wb_reg_write, wb_rd!=0 and wb_rd==rs1, operand1 = wb_data; otherwise read_data1. rs2 is handled identically. x0 always reads 0 regardless of read_data.
- Load-use hazard:
  - stall = if_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd matches a used rs1/rs2) & ~flush.
  - While stall=1, the next ID/EX content is a bubble: ex_valid=0 and all control 0. Data fields may hold any value.
  - IF/ID is held by upstream, so the same instruction re-decodes the following cycle. There, ex_mem_read=0 and stall deasserts: at most one stall cycle per load.
- Flush: has priority over stall and capture. The next ID/EX is a bubble and stall=0.
- Normal capture: ex_valid <= if_valid & legal opcode, with all fields loaded.
- if_valid=0: a bubble is loaded.
- Simultaneous flush and load-use: flush wins, no stall.
- WB to the same register as a stalled instruction's source: bypass applies on whichever cycle the instruction actually captures.
- Reset mid-stall: outputs clear immediately and stall drops.

Test Plan:
- Reset: assert rst with if_valid=1 and if_instr=0x00500293 (addi x5,x0,5) -> all ex_* = 0 and stall=0. Release rst -> next posedge gives ex_valid=1, ex_rd=5, ex_imm=5, ex_reg_write=1, ex_alu_src=1.
- WB bypass: RegisterFile x5=123 (read_data1 returns stale 0), wb_reg_write=1, wb_rd=5, wb_data=999, if_instr = add x10,x5,x0 -> ex_rs1_data=999, ex_rd=10. Repeat with WB_BYPASS=0 -> ex_rs1_data=0.
- Load-use: lw x6,0(x5) followed by add x7,x6,x6 -> stall=1 for exactly one cycle and one bubble (ex_valid=0) enters ID/EX. The add then captures with ex_rs1=ex_rs2=6. A load to x0 followed by a use of x0 -> no stall.
- Flush: assert flush during a normal capture and during a load-use condition -> ex_valid=0 next cycle and stall=0 in both cases.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) -> ex_imm=0xFFFFFFFC, ex_mem_write=1.
  - beq with offset -8 -> ex_imm=0xFFFFFFF8.
  - lui x3,0xABCDE -> ex_imm=0xABCDE000.
  - jal x1,+2048 -> ex_imm=0x00000800.
- Illegal opcode 0x0000007F -> ex_valid=0 and all control 0.
